// File: rtl/axi_stream_4_to_1_wrr_scheduler.sv
// Packet-granular weighted round-robin scheduler: four AXI Stream inputs share one
// registered output, and each grant carries whole packets until its beat budget is spent.
module axi_stream_4_to_1_wrr_scheduler #(
  parameter int AXIS_BUS_WIDTH     = 64,
  parameter int AXIS_IN_TID_WIDTH  = 1,
  parameter int AXIS_TDEST_WIDTH   = 1,
  parameter int AXIS_TUSER_WIDTH   = 1,
  parameter int QUANTUM_0          = 1,
  parameter int QUANTUM_1          = 1,
  parameter int QUANTUM_2          = 1,
  parameter int QUANTUM_3          = 1,
  parameter int BEAT_CNT_WIDTH     = 16,
  parameter int AXIS_OUT_TID_WIDTH = AXIS_IN_TID_WIDTH + 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_0_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_0_tkeep,
  input  logic [AXIS_IN_TID_WIDTH-1:0]  axis_in_0_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_0_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_0_tuser,
  input  logic                          axis_in_0_tlast,
  input  logic                          axis_in_0_tvalid,
  output logic                          axis_in_0_tready,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_1_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_1_tkeep,
  input  logic [AXIS_IN_TID_WIDTH-1:0]  axis_in_1_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_1_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_1_tuser,
  input  logic                          axis_in_1_tlast,
  input  logic                          axis_in_1_tvalid,
  output logic                          axis_in_1_tready,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_2_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_2_tkeep,
  input  logic [AXIS_IN_TID_WIDTH-1:0]  axis_in_2_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_2_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_2_tuser,
  input  logic                          axis_in_2_tlast,
  input  logic                          axis_in_2_tvalid,
  output logic                          axis_in_2_tready,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_3_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_3_tkeep,
  input  logic [AXIS_IN_TID_WIDTH-1:0]  axis_in_3_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_3_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_3_tuser,
  input  logic                          axis_in_3_tlast,
  input  logic                          axis_in_3_tvalid,
  output logic                          axis_in_3_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
  output logic [AXIS_OUT_TID_WIDTH-1:0] axis_out_tid,
  output logic [AXIS_TDEST_WIDTH-1:0]   axis_out_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_tuser,
  output logic                          axis_out_tlast,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic [1:0]                    arb_grant,
  output logic                          arb_busy
);

  localparam int KEEP_WIDTH = AXIS_BUS_WIDTH / 8;
  localparam int Q_EFF_0 = (QUANTUM_0 < 1) ? 1 : QUANTUM_0;
  localparam int Q_EFF_1 = (QUANTUM_1 < 1) ? 1 : QUANTUM_1;
  localparam int Q_EFF_2 = (QUANTUM_2 < 1) ? 1 : QUANTUM_2;
  localparam int Q_EFF_3 = (QUANTUM_3 < 1) ? 1 : QUANTUM_3;

  typedef enum logic {ARB, SEND} state_t;

  logic [AXIS_BUS_WIDTH-1:0]    in_tdata [4];
  logic [KEEP_WIDTH-1:0]        in_tkeep [4];
  logic [AXIS_IN_TID_WIDTH-1:0] in_tid   [4];
  logic [AXIS_TDEST_WIDTH-1:0]  in_tdest [4];
  logic [AXIS_TUSER_WIDTH-1:0]  in_tuser [4];
  logic [3:0]                   in_tlast;
  logic [3:0]                   in_tvalid;

  assign in_tdata[0] = axis_in_0_tdata;
  assign in_tdata[1] = axis_in_1_tdata;
  assign in_tdata[2] = axis_in_2_tdata;
  assign in_tdata[3] = axis_in_3_tdata;
  assign in_tkeep[0] = axis_in_0_tkeep;
  assign in_tkeep[1] = axis_in_1_tkeep;
  assign in_tkeep[2] = axis_in_2_tkeep;
  assign in_tkeep[3] = axis_in_3_tkeep;
  assign in_tid[0]   = axis_in_0_tid;
  assign in_tid[1]   = axis_in_1_tid;
  assign in_tid[2]   = axis_in_2_tid;
  assign in_tid[3]   = axis_in_3_tid;
  assign in_tdest[0] = axis_in_0_tdest;
  assign in_tdest[1] = axis_in_1_tdest;
  assign in_tdest[2] = axis_in_2_tdest;
  assign in_tdest[3] = axis_in_3_tdest;
  assign in_tuser[0] = axis_in_0_tuser;
  assign in_tuser[1] = axis_in_1_tuser;
  assign in_tuser[2] = axis_in_2_tuser;
  assign in_tuser[3] = axis_in_3_tuser;
  assign in_tlast    = {axis_in_3_tlast, axis_in_2_tlast, axis_in_1_tlast, axis_in_0_tlast};
  assign in_tvalid   = {axis_in_3_tvalid, axis_in_2_tvalid, axis_in_1_tvalid, axis_in_0_tvalid};

  state_t                    state_q, state_d;
  logic [1:0]                sel_q, sel_d;
  logic [1:0]                rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                      budget_open_q, budget_open_d;

  logic [AXIS_BUS_WIDTH-1:0]     out_tdata_q;
  logic [KEEP_WIDTH-1:0]         out_tkeep_q;
  logic [AXIS_OUT_TID_WIDTH-1:0] out_tid_q;
  logic [AXIS_TDEST_WIDTH-1:0]   out_tdest_q;
  logic [AXIS_TUSER_WIDTH-1:0]   out_tuser_q;
  logic                          out_tlast_q;
  logic                          out_tvalid_q;

  logic                      sel_ready;
  logic                      accept;
  logic                      found;
  logic [1:0]                winner;
  logic [BEAT_CNT_WIDTH-1:0] cnt_inc;
  logic [63:0]               cnt_inc_w;
  logic [63:0]               quantum_w;

  // tready is a function of registered state and the output handshake only.
  assign sel_ready = (state_q == SEND) && (!out_tvalid_q || axis_out_tready);
  assign accept    = sel_ready && in_tvalid[sel_q];
  assign cnt_inc   = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
  assign cnt_inc_w = 64'(cnt_inc);

  always_comb begin
    quantum_w = 64'(Q_EFF_0);
    case (sel_q)
      2'd1:    quantum_w = 64'(Q_EFF_1);
      2'd2:    quantum_w = 64'(Q_EFF_2);
      2'd3:    quantum_w = 64'(Q_EFF_3);
      default: quantum_w = 64'(Q_EFF_0);
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && in_tvalid[rr_ptr_q + 2'(k)]) begin
        found  = 1'b1;
        winner = rr_ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    budget_open_d = budget_open_q;
    case (state_q)
      ARB: begin
        if (found) begin
          state_d = SEND;
          sel_d   = winner;
          // A fresh grant restarts the budget; a continued grant keeps what was used.
          if (!(winner == sel_q && budget_open_q)) begin
            beat_cnt_d    = '0;
            budget_open_d = 1'b0;
          end
        end
      end
      SEND: begin
        if (accept) begin
          beat_cnt_d = cnt_inc;
          if (in_tlast[sel_q]) begin
            state_d = ARB;
            if (cnt_inc_w < quantum_w) begin
              rr_ptr_d      = sel_q;
              budget_open_d = 1'b1;
            end else begin
              rr_ptr_d      = sel_q + 2'd1;
              budget_open_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ARB;
      sel_q         <= 2'd0;
      rr_ptr_q      <= 2'd0;
      beat_cnt_q    <= '0;
      budget_open_q <= 1'b0;
      // NOTE: the payload is cleared too, since the output must read all-zero under reset.
      out_tdata_q   <= '0;
      out_tkeep_q   <= '0;
      out_tid_q     <= '0;
      out_tdest_q   <= '0;
      out_tuser_q   <= '0;
      out_tlast_q   <= 1'b0;
      out_tvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      budget_open_q <= budget_open_d;
      if (accept) begin
        out_tdata_q  <= in_tdata[sel_q];
        out_tkeep_q  <= in_tkeep[sel_q];
        out_tid_q    <= {sel_q, in_tid[sel_q]};
        out_tdest_q  <= in_tdest[sel_q];
        out_tuser_q  <= in_tuser[sel_q];
        out_tlast_q  <= in_tlast[sel_q];
        out_tvalid_q <= 1'b1;
      end else if (axis_out_tready) begin
        out_tvalid_q <= 1'b0;
      end
    end
  end

  assign axis_in_0_tready = sel_ready && (sel_q == 2'd0);
  assign axis_in_1_tready = sel_ready && (sel_q == 2'd1);
  assign axis_in_2_tready = sel_ready && (sel_q == 2'd2);
  assign axis_in_3_tready = sel_ready && (sel_q == 2'd3);

  assign axis_out_tdata  = out_tdata_q;
  assign axis_out_tkeep  = out_tkeep_q;
  assign axis_out_tid    = out_tid_q;
  assign axis_out_tdest  = out_tdest_q;
  assign axis_out_tuser  = out_tuser_q;
  assign axis_out_tlast  = out_tlast_q;
  assign axis_out_tvalid = out_tvalid_q;
  assign arb_grant       = sel_q;
  assign arb_busy        = (state_q == SEND);

endmodule

// File: doc/axi_stream_4_to_1_wrr_scheduler.md
# axi_stream_4_to_1_wrr_scheduler

Packet-granular weighted round-robin scheduler that shares one AXI Stream output among four input streams, for use where several virtualized producers feed one shared link.
- Each grant lets an input send whole packets until its per-grant beat budget (QUANTUM_#) is used up.
- Packets are never split or interleaved.
- The output is a single register stage tagged with the source number in TID.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64, tdata width; tkeep is AXIS_BUS_WIDTH/8.
- AXIS_IN_TID_WIDTH, 1, input tid width.
- AXIS_TDEST_WIDTH, 1, tdest width.
- AXIS_TUSER_WIDTH, 1, tuser width.
- QUANTUM_0..QUANTUM_3, 1, beat budget per grant for input #. A value of 0 is treated as 1.
- BEAT_CNT_WIDTH, 16, width of the budget counter. The counter saturates.
- AXIS_OUT_TID_WIDTH, AXIS_IN_TID_WIDTH+2, derived; do not override.

Ports:
- aclk  in  1  single clock; all interfaces are synchronous to it.
- areset  in  1  reset, synchronous, active-high.
- axis_in_#_tdata/tkeep/tid/tdest/tuser/tlast/tvalid  in  per parameters  input stream #, where # is 0..3.
- axis_in_#_tready  out  1  ready for input #.
- axis_out_tdata/tkeep/tdest/tuser/tlast  out  per parameters  output stream payload.
- axis_out_tid  out  AXIS_OUT_TID_WIDTH  {source number[1:0], input tid}.
- axis_out_tvalid  out  1  output valid.
- axis_out_tready  in  1  output ready.
- arb_grant  out  2  currently selected input (sel).
- arb_busy  out  1  high while in SEND.

## Operation
Registers:
- state: ARB or SEND.
- sel[1:0].
- rr_ptr[1:0].
- beat_cnt[BEAT_CNT_WIDTH-1:0].
- budget_open.
- output register slice.

Reset: while areset is high, on every clock edge:
- state=ARB, sel=0, rr_ptr=0, beat_cnt=0, budget_open=0.
- All axis_out_* = 0, so axis_out_tvalid=0.
- All axis_in_#_tready = 0, arb_grant=0, arb_busy=0.
- A packet in flight is abandoned. Its remaining beats are delivered as a new packet after reset; no mid-packet recovery.

ARB state (one cycle):
- Scan the inputs rr_ptr, rr_ptr+1, … mod 4. The first one with axis_in_#_tvalid=1 is the winner.
- If no input is valid, stay in ARB with all registers unchanged.
- Otherwise set sel=winner and go to SEND.
- If winner==sel and budget_open=1, keep beat_cnt. Otherwise clear beat_cnt to 0 and budget_open to 0.

SEND state:
- axis_in_sel_tready = !axis_out_tvalid || axis_out_tready. All other treadys are 0.
- On accepting a beat from the selected input:
  - Load the output register with that input's payload.
  - Set axis_out_tid = {sel, in_tid} and axis_out_tvalid=1.
  - beat_cnt = beat_cnt+1, saturating.
- Accepting tlast ends the packet and returns to ARB:
  - If beat_cnt+1 < Q(sel): rr_ptr=sel and budget_open=1, so the same input may continue.
  - Otherwise: rr_ptr=sel+1 mod 4 and budget_open=0.
- A packet always completes, even if it exceeds the budget. There is no debt carried over to later grants.
- If sel is not valid when ARB is re-entered, the scan naturally moves on and the remaining budget is forfeited.

Output slice:
- axis_out_tvalid clears when axis_out_tready=1 and no new beat is loaded that cycle.
- Payload registers hold while axis_out_tvalid=1 && axis_out_tready=0.

## Timing
- Latency: a beat accepted at edge N appears on the output after edge N, i.e. one cycle.
- Arbitration costs exactly one bubble cycle per packet: tready is low during the ARB cycle.
- Within a packet, throughput is one beat per cycle when axis_out_tready=1.
- tready depends only on registered state and axis_out_tready. There is no combinational path from any input tvalid to any tready.
- Simultaneous events:
  - If tlast is accepted while the output is stalled, state still goes to ARB. The next load waits for the output register to drain via the tready equation.
- Input tvalid is sampled only in ARB, for winner selection, and in SEND, for sel only.

## Test plan
- Reset: hold areset for 3 cycles while all inputs are valid -> axis_out_tvalid=0, all treadys 0, arb_busy=0. After release, the first grant goes to input 0.
- Single source: input 2 sends a 3-beat packet (tdata 0xA,0xB,0xC, tid=1), axis_out_tready=1 -> one ARB cycle, then 3 consecutive output beats 0xA,0xB,0xC. Each has tid=3'b101, tlast only on 0xC. arb_grant=2.
- Plain round robin: all quanta 1, all inputs continuously offering 2-beat packets -> output packet sources in order 0,1,2,3,0,1…, with one bubble between packets.
- Weighted: QUANTUM_0=4, others 1, all inputs offering 2-beat packets -> source order 0,0,1,2,3,0,0,1…. With QUANTUM_0=3, the order is the same: the second packet overruns the budget and still completes.
- Backpressure: axis_out_tready=0 for 5 cycles mid-packet -> output payload stable, input tready=0, no beats lost or duplicated. Delivery resumes the cycle after tready rises.
- Reset mid-packet: assert areset during beat 2 of a 4-beat packet -> axis_out_tvalid=0 on the next edge. After release, arbitration restarts from input 0 with beat_cnt=0.
